// File: rtl/menu_input_ctl_if.sv
// Pushbutton inputs, downstream state feedback and conditioned outputs
// of the menu input front end.
interface menu_input_ctl_if;
    logic       btnC_raw;
    logic       btnL_raw;
    logic       btnR_raw;
    logic       btnU_raw;
    logic       btnD_raw;
    logic [2:0] app_state;
    logic       btnC;
    logic       btnL;
    logic       btnR;
    logic [2:0] menu_state;
    logic       cursor_moved;

    modport master (
        output btnC_raw, btnL_raw, btnR_raw, btnU_raw, btnD_raw,
        output app_state,
        input  btnC, btnL, btnR, menu_state, cursor_moved
    );

    modport slave (
        input  btnC_raw, btnL_raw, btnR_raw, btnU_raw, btnD_raw,
        input  app_state,
        output btnC, btnL, btnR, menu_state, cursor_moved
    );
endinterface

// File: rtl/menu_input_ctl.sv
// Button conditioning (sync, debounce, press pulse) and menu cursor
// with wrap-around and auto-repeat on up/down.
module menu_input_ctl #(
    parameter int DB_CYCLES    = 1_000_000,
    parameter int REPEAT_DELAY = 50_000_000,
    parameter int REPEAT_RATE  = 15_000_000,
    parameter int NUM_ITEMS    = 4
) (
    input  logic clk,
    input  logic rst_n,
    menu_input_ctl_if.slave bus
);
    localparam int CW   = $clog2(DB_CYCLES + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY
                                                       : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [2:0]    NI   = 3'(NUM_ITEMS);
    localparam logic [CW-1:0] DBM1 = CW'(DB_CYCLES - 1);
    localparam logic [RW-1:0] RDLY = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] RRAT = RW'(REPEAT_RATE);

    // bit order: 0=C 1=L 2=R 3=U 4=D
    logic [4:0] raw;
    logic [4:0] s1_q, s2_q;
    logic [4:0] stable_q, stable_d;
    logic [4:0] pulse_q, pulse_d;
    logic [CW-1:0] cnt_q [5];
    logic [CW-1:0] cnt_d [5];

    // repeat state, index 0=U 1=D
    logic [RW-1:0] rep_q [2];
    logic [RW-1:0] rep_d [2];
    logic [1:0]    ph_q, ph_d;
    logic [1:0]    rstep;
    logic          menu_en;
    logic          step_u, step_d;

    logic [2:0] ms_q, ms_d;
    logic       moved_q, moved_d;

    assign raw = {bus.btnD_raw, bus.btnU_raw, bus.btnR_raw,
                  bus.btnL_raw, bus.btnC_raw};

    always_comb begin
        stable_d = stable_q;
        pulse_d  = '0;
        for (int b = 0; b < 5; b++) begin
            cnt_d[b] = '0;
            if (s2_q[b] != stable_q[b]) begin
                if (cnt_q[b] == DBM1) begin
                    stable_d[b] = s2_q[b];
                    pulse_d[b]  = s2_q[b];
                end else begin
                    cnt_d[b] = cnt_q[b] + CW'(1);
                end
            end
        end
    end

    assign menu_en = (bus.app_state == 3'd0);

    // Counter starts at 1 on the press pulse; phase 0 waits for the
    // initial delay, phase 1 for the repeat period.
    always_comb begin
        ph_d  = ph_q;
        rstep = '0;
        for (int d = 0; d < 2; d++) begin
            rep_d[d] = rep_q[d];
            if (!stable_q[3+d] || !menu_en) begin
                rep_d[d] = '0;
                ph_d[d]  = 1'b0;
            end else if (pulse_q[3+d]) begin
                rep_d[d] = RW'(1);
                ph_d[d]  = 1'b0;
            end else if (rep_q[d] != '0) begin
                if ((!ph_q[d] && rep_q[d] == RDLY) ||
                    (ph_q[d] && rep_q[d] == RRAT)) begin
                    rstep[d] = 1'b1;
                    rep_d[d] = RW'(1);
                    ph_d[d]  = 1'b1;
                end else begin
                    rep_d[d] = rep_q[d] + RW'(1);
                end
            end
        end
    end

    assign step_u = menu_en && (pulse_q[3] || rstep[0]);
    assign step_d = menu_en && (pulse_q[4] || rstep[1]);

    always_comb begin
        ms_d = ms_q;
        if (step_d && !step_u)
            ms_d = (ms_q >= NI) ? 3'd1 : ms_q + 3'd1;
        else if (step_u && !step_d)
            ms_d = (ms_q <= 3'd1) ? NI : ms_q - 3'd1;
        moved_d = (ms_d != ms_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q     <= '0;
            s2_q     <= '0;
            stable_q <= '0;
            pulse_q  <= '0;
            for (int b = 0; b < 5; b++) cnt_q[b] <= '0;
            for (int d = 0; d < 2; d++) rep_q[d] <= '0;
            ph_q     <= '0;
            ms_q     <= 3'd1;
            moved_q  <= 1'b0;
        end else begin
            s1_q     <= raw;
            s2_q     <= s1_q;
            stable_q <= stable_d;
            pulse_q  <= pulse_d;
            for (int b = 0; b < 5; b++) cnt_q[b] <= cnt_d[b];
            for (int d = 0; d < 2; d++) rep_q[d] <= rep_d[d];
            ph_q     <= ph_d;
            ms_q     <= ms_d;
            moved_q  <= moved_d;
        end
    end

    assign bus.btnC         = pulse_q[0];
    assign bus.btnL         = pulse_q[1];
    assign bus.btnR         = pulse_q[2];
    assign bus.menu_state   = ms_q;
    assign bus.cursor_moved = moved_q;
endmodule

// File: tb/tb_menu_input_ctl.sv
// Directed bench for menu_input_ctl with small debounce/repeat params.
module tb_menu_input_ctl;
    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RR = 8;
    localparam int NI = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    menu_input_ctl_if bus ();

    menu_input_ctl #(
        .DB_CYCLES    (DB),
        .REPEAT_DELAY (RD),
        .REPEAT_RATE  (RR),
        .NUM_ITEMS    (NI)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // 0=C 1=L 2=R 3=U 4=D
    task automatic set_btn(input int b, input logic v);
        case (b)
            0: bus.btnC_raw = v;
            1: bus.btnL_raw = v;
            2: bus.btnR_raw = v;
            3: bus.btnU_raw = v;
            default: bus.btnD_raw = v;
        endcase
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_reset();
        tick(3);
        n_checks++;
        if (bus.menu_state !== 3'd1) begin
            n_fail++;
            $display("FAIL reset_menu got %0d want 1", bus.menu_state);
        end
        n_checks++;
        if ({bus.btnC, bus.btnL, bus.btnR, bus.cursor_moved} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_pulses got %b want 0000",
                     {bus.btnC, bus.btnL, bus.btnR, bus.cursor_moved});
        end
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_reset_mid_hold();
        for (int i = 0; i < 2; i++) begin
            set_btn(4, 1'b1);
            tick(7);
            set_btn(4, 1'b0);
            tick(8);
        end
        n_checks++;
        if (bus.menu_state !== 3'd3) begin
            n_fail++;
            $display("FAIL pre_reset_menu got %0d want 3", bus.menu_state);
        end
        set_btn(4, 1'b1);
        tick(3);
        rst_n = 1'b0;
        #2;
        n_checks++;
        if (bus.menu_state !== 3'd1 || bus.cursor_moved !== 1'b0 ||
            {bus.btnC, bus.btnL, bus.btnR} !== 3'b0) begin
            n_fail++;
            $display("FAIL async_reset got menu=%0d mv=%b p=%b want 1 0 000",
                     bus.menu_state, bus.cursor_moved,
                     {bus.btnC, bus.btnL, bus.btnR});
        end
        tick(2);
        rst_n = 1'b1;
        tick(7);
        n_checks++;
        if (bus.menu_state !== 3'd2 || bus.cursor_moved !== 1'b1) begin
            n_fail++;
            $display("FAIL held_after_reset got menu=%0d mv=%b want 2 1",
                     bus.menu_state, bus.cursor_moved);
        end
        set_btn(4, 1'b0);
        tick(10);
    endtask

    task automatic test_bounce();
        int pulses;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            bus.btnC_raw = ((i / 2) % 2 == 0);
            tick(1);
            if (bus.btnC === 1'b1) pulses++;
        end
        bus.btnC_raw = 1'b1;
        tick(2);
        n_checks++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL bounce_pulses got %0d want 0", pulses);
        end
        for (int k = 3; k <= 10; k++) begin
            tick(1);
            n_checks++;
            if (bus.btnC !== (k == DB + 2)) begin
                n_fail++;
                $display("FAIL bounce_edge%0d got %b want %b",
                         k, bus.btnC, (k == DB + 2));
            end
        end
        bus.btnC_raw = 1'b0;
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            if (bus.btnC === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL release_pulse got %0d want 0", pulses);
        end
    endtask

    task automatic test_taps();
        logic [2:0] exp_m [5];
        int         btn   [5];
        exp_m = '{3'd2, 3'd3, 3'd4, 3'd1, 3'd4};
        btn   = '{4, 4, 4, 4, 3};
        do_reset();
        bus.app_state = 3'd0;
        for (int i = 0; i < 5; i++) begin
            set_btn(btn[i], 1'b1);
            tick(7);
            n_checks++;
            if (bus.menu_state !== exp_m[i] || bus.cursor_moved !== 1'b1) begin
                n_fail++;
                $display("FAIL tap%0d got menu=%0d mv=%b want %0d 1",
                         i, bus.menu_state, bus.cursor_moved, exp_m[i]);
            end
            tick(1);
            n_checks++;
            if (bus.cursor_moved !== 1'b0) begin
                n_fail++;
                $display("FAIL tap%0d_mv_width got %b want 0",
                         i, bus.cursor_moved);
            end
            set_btn(btn[i], 1'b0);
            tick(8);
        end
    endtask

    task automatic test_auto_repeat();
        logic [2:0] em;
        int         moves;
        logic       step;
        em    = bus.menu_state;
        moves = 0;
        bus.btnD_raw = 1'b1;
        tick(DB + 2);
        for (int j = 1; j <= 70; j++) begin
            tick(1);
            step = (j - 1 == 0) ||
                   (j - 1 >= RD && (j - 1 - RD) % RR == 0);
            if (step) em = (em == 3'(NI)) ? 3'd1 : em + 3'd1;
            if (bus.cursor_moved === 1'b1) moves++;
            if (bus.cursor_moved !== step || bus.menu_state !== em) begin
                n_fail++;
                $display("FAIL repeat_p%0d got menu=%0d mv=%b want %0d %b",
                         j - 1, bus.menu_state, bus.cursor_moved, em, step);
            end
        end
        n_checks++;
        if (moves != 8) begin
            n_fail++;
            $display("FAIL repeat_count got %0d want 8", moves);
        end
        n_checks++;
        if (bus.menu_state !== em) begin
            n_fail++;
            $display("FAIL repeat_final got %0d want %0d", bus.menu_state, em);
        end
        bus.btnD_raw = 1'b0;
        moves = 0;
        for (int k = 0; k < 30; k++) begin
            tick(1);
            if (bus.cursor_moved === 1'b1) moves++;
        end
        n_checks++;
        if (moves != 0 || bus.menu_state !== em) begin
            n_fail++;
            $display("FAIL repeat_release got moves=%0d menu=%0d want 0 %0d",
                     moves, bus.menu_state, em);
        end
    endtask

    task automatic test_app_busy();
        logic [2:0] m0;
        int         moves;
        logic [2:0] want;
        logic [2:0] got;
        m0 = bus.menu_state;
        bus.app_state = 3'd3;
        moves = 0;
        for (int b = 3; b <= 4; b++) begin
            set_btn(b, 1'b1);
            for (int k = 0; k < 10; k++) begin
                tick(1);
                if (bus.cursor_moved === 1'b1) moves++;
            end
            set_btn(b, 1'b0);
            tick(8);
        end
        n_checks++;
        if (moves != 0 || bus.menu_state !== m0) begin
            n_fail++;
            $display("FAIL busy_cursor got moves=%0d menu=%0d want 0 %0d",
                     moves, bus.menu_state, m0);
        end
        for (int b = 0; b < 3; b++) begin
            want = 3'b100 >> b;
            set_btn(b, 1'b1);
            tick(DB + 2);
            got = {bus.btnC, bus.btnL, bus.btnR};
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL busy_pulse%0d got %b want %b", b, got, want);
            end
            tick(1);
            got = {bus.btnC, bus.btnL, bus.btnR};
            n_checks++;
            if (got !== 3'b000) begin
                n_fail++;
                $display("FAIL busy_pulse%0d_width got %b want 000", b, got);
            end
            set_btn(b, 1'b0);
            tick(8);
        end
        bus.app_state = 3'd0;
        tick(1);
    endtask

    task automatic test_simultaneous();
        logic [2:0] m0;
        int         moves;
        m0 = bus.menu_state;
        moves = 0;
        bus.btnU_raw = 1'b1;
        bus.btnD_raw = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick(1);
            if (bus.cursor_moved === 1'b1) moves++;
        end
        n_checks++;
        if (moves != 0 || bus.menu_state !== m0) begin
            n_fail++;
            $display("FAIL simul_ud got moves=%0d menu=%0d want 0 %0d",
                     moves, bus.menu_state, m0);
        end
        bus.btnU_raw = 1'b0;
        bus.btnD_raw = 1'b0;
        tick(10);
    endtask

    initial begin
        bus.btnC_raw  = 1'b0;
        bus.btnL_raw  = 1'b0;
        bus.btnR_raw  = 1'b0;
        bus.btnU_raw  = 1'b0;
        bus.btnD_raw  = 1'b0;
        bus.app_state = 3'd0;
        test_reset();
        test_reset_mid_hold();
        test_bounce();
        test_taps();
        test_auto_repeat();
        test_app_busy();
        test_simultaneous();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
